// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, flag indices and result-entry layout for the ALU result stage
package alu_pkg;

  // ALU op codes as driven on in_ctrl
  typedef enum logic [3:0] {
    ADD     = 4'd0,
    SUB     = 4'd1,
    AND     = 4'd2,
    OR      = 4'd3,
    XOR     = 4'd4,
    NOR     = 4'd5,
    SLL     = 4'd6,
    SRL     = 4'd7,
    SRA     = 4'd8,
    PASS_A  = 4'd9,
    PASS_B  = 4'd10,
    SLT     = 4'd11,
    SLTU    = 4'd12,
    BEQ     = 4'd13,
    BNEQ    = 4'd14,
    ILLEGAL = 4'd15
  } alu_op_e;

  // Bit positions inside the 4-bit flag field {neg, zero, cout, overflow}
  localparam int FLG_NEG  = 3;
  localparam int FLG_ZERO = 2;
  localparam int FLG_COUT = 1;
  localparam int FLG_OVF  = 0;

  // Flags stored for an illegal op: only zero set, matching the forced zero result
  localparam logic [3:0] ILLEGAL_FLAGS = 4'b0100;

  // Entry layout {res, flags, ctrl, illegal}; total width is W + ENT_META_W
  localparam int ENT_META_W   = 9;
  localparam int ENT_ILL      = 0;
  localparam int ENT_CTRL_LSB = 1;
  localparam int ENT_FLG_LSB  = 5;
  localparam int ENT_RES_LSB  = 9;

  // Ops whose result bit 0 is a branch/compare outcome
  function automatic logic is_branch_op(input logic [3:0] ctrl);
    return (ctrl >= SLT) && (ctrl <= BNEQ);
  endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// rtl/alu_skid_buf.sv - generic 2-entry valid/ready FIFO buffer with registered handshake outputs
module alu_skid_buf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] head;
  logic [DW-1:0] tail;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          push;
  logic          pop;

  // Handshakes only look at registered ready/valid, so out_ready never reaches in_ready
  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  // Buffer FSM: head is always the oldest entry; head is zeroed whenever the buffer empties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_EMPTY;
      head        <= '0;
      tail        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (push) begin
            head        <= in_data;
            out_valid_q <= 1'b1;
            state       <= S_ONE;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            head <= in_data;
          end else if (push) begin
            tail       <= in_data;
            in_ready_q <= 1'b0;
            state      <= S_TWO;
          end else if (pop) begin
            head        <= '0;
            out_valid_q <= 1'b0;
            state       <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (pop) begin
            head       <= tail;
            tail       <= '0;
            in_ready_q <= 1'b1;
            state      <= S_ONE;
          end
        end
        default: begin
          state       <= S_EMPTY;
          head        <= '0;
          tail        <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head;

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered ALU result stage: sanitising, skid buffer, sticky status, retire counter
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_ctrl,
  input  logic [W-1:0]     in_res,
  input  logic             in_cout,
  input  logic             in_neg,
  input  logic             in_overflow,
  input  logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_res,
  output logic [3:0]       out_flags,
  output logic [3:0]       out_ctrl,
  output logic             out_illegal,
  output logic             out_branch,
  input  logic             clear_sticky,
  output logic             sticky_carry,
  output logic             sticky_ovf,
  output logic             sticky_illegal,
  output logic [CNT_W-1:0] op_count
);

  localparam int ENT_W = W + ENT_META_W;

  logic             is_illegal;
  logic [3:0]       raw_flags;
  logic [3:0]       san_flags;
  logic [W-1:0]     san_res;
  logic [ENT_W-1:0] entry_in;
  logic [ENT_W-1:0] entry_out;
  logic             push;
  logic             pop;

  assign is_illegal = (in_ctrl == ILLEGAL);

  // Gather ALU flags into the {neg, zero, cout, overflow} field
  always_comb begin
    raw_flags           = '0;
    raw_flags[FLG_NEG]  = in_neg;
    raw_flags[FLG_ZERO] = in_zero;
    raw_flags[FLG_COUT] = in_cout;
    raw_flags[FLG_OVF]  = in_overflow;
  end

  // An illegal op leaves the ALU result undefined, so it is replaced before reaching a flop
  assign san_res   = is_illegal ? '0 : in_res;
  assign san_flags = is_illegal ? ILLEGAL_FLAGS : raw_flags;
  assign entry_in  = {san_res, san_flags, in_ctrl, is_illegal};

  alu_skid_buf #(
    .DW (ENT_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (entry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (entry_out)
  );

  assign out_res     = entry_out[ENT_RES_LSB +: W];
  assign out_flags   = entry_out[ENT_FLG_LSB +: 4];
  assign out_ctrl    = entry_out[ENT_CTRL_LSB +: 4];
  assign out_illegal = entry_out[ENT_ILL];
  // The buffer zeroes its head when empty, and op 0 is not a branch, so this is 0 when empty
  assign out_branch  = is_branch_op(out_ctrl) & out_res[0];

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Sticky status: clear drops old state, a same-cycle set still lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_carry   <= 1'b0;
      sticky_ovf     <= 1'b0;
      sticky_illegal <= 1'b0;
    end else begin
      sticky_carry   <= (sticky_carry & ~clear_sticky) | (push & (in_ctrl <= SUB) & in_cout);
      sticky_ovf     <= (sticky_ovf & ~clear_sticky) | (push & in_overflow);
      sticky_illegal <= (sticky_illegal & ~clear_sticky) | (push & is_illegal);
    end
  end

  // Retired-op counter, free-running wrap on overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (pop) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - self-checking bench for alu_result_stage
module tb_alu_result_stage;
  import alu_pkg::*;

  localparam int W     = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_ctrl = '0;
  logic [W-1:0]     in_res = '0;
  logic             in_cout = 1'b0;
  logic             in_neg = 1'b0;
  logic             in_overflow = 1'b0;
  logic             in_zero = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_res;
  logic [3:0]       out_flags;
  logic [3:0]       out_ctrl;
  logic             out_illegal;
  logic             out_branch;
  logic             clear_sticky = 1'b0;
  logic             sticky_carry;
  logic             sticky_ovf;
  logic             sticky_illegal;
  logic [CNT_W-1:0] op_count;

  always #5 clk = ~clk;

  alu_result_stage #(.W(W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_ctrl        (in_ctrl),
    .in_res         (in_res),
    .in_cout        (in_cout),
    .in_neg         (in_neg),
    .in_overflow    (in_overflow),
    .in_zero        (in_zero),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_res        (out_res),
    .out_flags      (out_flags),
    .out_ctrl       (out_ctrl),
    .out_illegal    (out_illegal),
    .out_branch     (out_branch),
    .clear_sticky   (clear_sticky),
    .sticky_carry   (sticky_carry),
    .sticky_ovf     (sticky_ovf),
    .sticky_illegal (sticky_illegal),
    .op_count       (op_count)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a FIFO of sanitised entries plus sticky bits and a pop count
  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    logic [3:0]  ctrl;
    logic        ill;
  } ent_t;

  ent_t        mq[$];
  logic        m_sc  = 1'b0;
  logic        m_so  = 1'b0;
  logic        m_si  = 1'b0;
  logic [15:0] m_cnt = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_sc  <= 1'b0;
      m_so  <= 1'b0;
      m_si  <= 1'b0;
      m_cnt <= '0;
    end else begin
      automatic bit   push = in_valid && (mq.size() < 2);
      automatic bit   pop  = out_ready && (mq.size() > 0);
      automatic ent_t e;
      automatic bit   sc = push && (in_ctrl <= 4'd1) && in_cout;
      automatic bit   so = push && in_overflow;
      automatic bit   si = push && (in_ctrl == 4'd15);
      m_sc <= (m_sc && !clear_sticky) || sc;
      m_so <= (m_so && !clear_sticky) || so;
      m_si <= (m_si && !clear_sticky) || si;
      if (pop) begin
        mq.delete(0);
        m_cnt <= m_cnt + 16'd1;
      end
      if (push) begin
        if (in_ctrl == 4'd15) begin
          e.res = 32'd0; e.flg = 4'b0100; e.ctrl = 4'd15; e.ill = 1'b1;
        end else begin
          e.res = in_res; e.flg = {in_neg, in_zero, in_cout, in_overflow};
          e.ctrl = in_ctrl; e.ill = 1'b0;
        end
        mq.push_back(e);
      end
    end
  end

  // Every falling edge: DUT outputs must match the model's head and status
  always @(negedge clk) begin
    automatic bit   v = (mq.size() > 0);
    automatic ent_t h;
    automatic bit   br;
    if (v) h = mq[0];
    else begin h.res = 0; h.flg = 0; h.ctrl = 0; h.ill = 0; end
    br = v && (h.ctrl >= 4'd11) && (h.ctrl <= 4'd14) && h.res[0];
    chk("in_ready",       in_ready,       mq.size() < 2);
    chk("out_valid",      out_valid,      v);
    chk("out_res",        out_res,        h.res);
    chk("out_flags",      out_flags,      h.flg);
    chk("out_ctrl",       out_ctrl,       h.ctrl);
    chk("out_illegal",    out_illegal,    h.ill);
    chk("out_branch",     out_branch,     br);
    chk("sticky_carry",   sticky_carry,   m_sc);
    chk("sticky_ovf",     sticky_ovf,     m_so);
    chk("sticky_illegal", sticky_illegal, m_si);
    chk("op_count",       op_count,       m_cnt);
  end

  // Drive one cycle of inputs; returns at the falling edge after the capturing rising edge
  task automatic step(input bit v, input logic [3:0] c, input logic [31:0] r,
                      input logic [3:0] f, input bit ordy, input bit clr);
    in_valid = v;
    in_ctrl  = c;
    in_res   = r;
    {in_neg, in_zero, in_cout, in_overflow} = f;
    out_ready    = ordy;
    clear_sticky = clr;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_op_count", op_count, 0);

    // Single ADD through with consumer ready
    step(1, ADD, 32'h5, 4'h0, 1, 0);
    chk("t1_valid", out_valid, 1);
    chk("t1_res", out_res, 5);
    chk("t1_flags", out_flags, 0);
    step(0, ADD, 0, 0, 1, 0);
    chk("t1_count", op_count, 1);
    chk("t1_empty", out_valid, 0);

    // Back-pressure: third push refused, order kept
    step(1, ADD, 32'h1, 0, 0, 0);
    chk("t2_res1", out_res, 1);
    chk("t2_ready1", in_ready, 1);
    step(1, ADD, 32'h2, 0, 0, 0);
    chk("t2_ready2", in_ready, 0);
    step(1, ADD, 32'h3, 0, 0, 0);
    chk("t2_ready3", in_ready, 0);
    chk("t2_hold", out_res, 1);
    step(0, ADD, 0, 0, 1, 0);
    chk("t2_res2", out_res, 2);
    chk("t2_ready4", in_ready, 1);
    step(0, ADD, 0, 0, 1, 0);
    chk("t2_drained", out_valid, 0);
    chk("t2_count", op_count, 3);

    // Illegal op sanitising
    step(1, ILLEGAL, 'x, 0, 0, 0);
    chk("t3_res", out_res, 0);
    chk("t3_flags", out_flags, 4'b0100);
    chk("t3_ill", out_illegal, 1);
    chk("t3_sticky", sticky_illegal, 1);
    step(1, ILLEGAL, 32'hDEADBEEF, 4'b1010, 1, 0);
    chk("t3_res_b", out_res, 0);
    chk("t3_flags_b", out_flags, 4'b0100);
    chk("t3_nocarry", sticky_carry, 0);
    step(0, ADD, 0, 0, 1, 1);
    chk("t3_clear", sticky_illegal, 0);
    chk("t3_count", op_count, 5);

    // Sticky set wins over clear; clear alone zeroes
    step(1, SUB, 32'h0, 4'b0011, 1, 1);
    chk("t4_ovf", sticky_ovf, 1);
    chk("t4_carry", sticky_carry, 1);
    step(0, ADD, 0, 0, 1, 1);
    chk("t4_ovf_clr", sticky_ovf, 0);
    chk("t4_carry_clr", sticky_carry, 0);
    step(1, AND, 32'h0, 4'b0010, 1, 0);
    chk("t4_and_carry", sticky_carry, 0);
    step(1, ADD, 32'h0, 4'b0010, 1, 0);
    chk("t4_add_carry", sticky_carry, 1);
    step(0, ADD, 0, 0, 1, 1);

    // Branch decode
    step(1, SLT, 32'h1, 0, 1, 0);
    chk("t5_slt", out_branch, 1);
    step(1, BEQ, 32'h0, 4'b0100, 1, 0);
    chk("t5_beq", out_branch, 0);
    chk("t5_beq_ctrl", out_ctrl, 13);
    step(1, AND, 32'h1, 0, 1, 0);
    chk("t5_and", out_branch, 0);
    step(1, BNEQ, 32'h3, 0, 1, 0);
    chk("t5_bneq", out_branch, 1);
    step(1, PASS_B, 32'h1, 0, 1, 0);
    chk("t5_passb", out_branch, 0);
    step(0, ADD, 0, 0, 1, 0);
    chk("t5_count", op_count, 13);

    // Stream until the counter is all-ones, then one more pop wraps it
    in_valid = 1; in_ctrl = ADD; in_res = 32'h1234;
    {in_neg, in_zero, in_cout, in_overflow} = 4'b0000;
    out_ready = 1; clear_sticky = 0;
    g = 0;
    while (m_cnt != 16'hFFFF && g < 70000) begin
      @(negedge clk);
      g++;
    end
    chk("wrap_reached", op_count, 16'hFFFF);
    in_valid = 0;
    @(negedge clk);
    chk("wrap_zero", op_count, 0);
    chk("wrap_empty", out_valid, 0);

    // Reset in the middle of a burst with both entries held
    step(1, ADD, 32'h7, 4'b0001, 0, 0);
    step(1, SUB, 32'h8, 0, 1, 0);
    step(1, ADD, 32'h9, 0, 0, 0);
    chk("t6_full", in_ready, 0);
    chk("t6_count", op_count, 1);
    chk("t6_ovf", sticky_ovf, 1);
    chk("t6_head", out_res, 8);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_res", out_res, 0);
    chk("t6_rst_ctrl", out_ctrl, 0);
    chk("t6_rst_ready", in_ready, 1);
    chk("t6_rst_count", op_count, 0);
    chk("t6_rst_ovf", sticky_ovf, 0);
    in_valid = 0; out_ready = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, ADD, 0, 0, 1, 0);
    chk("t6_after", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
